// File: rtl/forwarding_control_unit.sv
// forwarding_control_unit: EX-stage operand forwarding selects, load-use
// stall/bubble generation and a saturating stall-cycle counter.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   id_rs_i, id_rt_i      source registers of the instruction in ID
//   id_uses_rt_i          ID instruction reads rt
//   id_write_reg_i        destination register of the ID instruction
//   id_reg_write_i        ID instruction writes the register file
//   id_mem_read_i         ID instruction is a load
//   id_valid_i            ID holds a real instruction
//   flush_i               squash the ID instruction (taken branch/jump)
//   forward_a_o/b_o       operand mux selects (00 RF, 01 MEM/WB, 10 EX/MEM)
//   stall_o               hold PC and IF/ID
//   bubble_o              zero control bits entering ID/EX
//   stall_count_o         saturating count of stall cycles
//
// Build option: FORWARDING_CONTROL_FORWARDING_EN enables the forwarding
// network. Without it, the selects are tied to the register file and
// any pending producer in ID/EX or EX/MEM stalls the consumer.

module forwarding_control_unit #(
    parameter int REG_BITS = 5,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_BITS-1:0] id_rs_i,
    input  logic [REG_BITS-1:0] id_rt_i,
    input  logic                id_uses_rt_i,
    input  logic [REG_BITS-1:0] id_write_reg_i,
    input  logic                id_reg_write_i,
    input  logic                id_mem_read_i,
    input  logic                id_valid_i,
    input  logic                flush_i,
    output logic [1:0]          forward_a_o,
    output logic [1:0]          forward_b_o,
    output logic                stall_o,
    output logic                bubble_o,
    output logic [CNT_BITS-1:0] stall_count_o
);

    typedef struct packed {
        logic                valid;
        logic                reg_write;
        logic                mem_read;
        logic [REG_BITS-1:0] write_reg;
        logic [REG_BITS-1:0] rs;
        logic [REG_BITS-1:0] rt;
        logic                uses_rt;
    } tag_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    tag_t idex;
    tag_t exmem;
    tag_t memwb;
    tag_t idex_next;

    logic                hazard;
    logic [CNT_BITS-1:0] stall_cnt;

    // A stage produces register r; $0 is never a real producer.
    function automatic logic writes(input tag_t t,
                                    input logic [REG_BITS-1:0] r);
        return t.valid && t.reg_write &&
               (t.write_reg == r) && (r != '0);
    endfunction

    // A stage produces one of the sources read by the ID instruction.
    function automatic logic src_hit(input tag_t t);
        return writes(t, id_rs_i) ||
               (id_uses_rt_i && writes(t, id_rt_i));
    endfunction

`ifdef FORWARDING_CONTROL_FORWARDING_EN

    // Only a load in EX cannot be forwarded in time for the ID consumer.
    assign hazard = id_valid_i && idex.valid && idex.mem_read &&
                    src_hit(idex);

    // EX/MEM holds the younger result, so it wins a double match.
    always_comb begin
        forward_a_o = SEL_RF;
        if (idex.valid) begin
            if (writes(exmem, idex.rs)) begin
                forward_a_o = SEL_MEM;
            end else if (writes(memwb, idex.rs)) begin
                forward_a_o = SEL_WB;
            end
        end
    end

    always_comb begin
        forward_b_o = SEL_RF;
        if (idex.valid && idex.uses_rt) begin
            if (writes(exmem, idex.rt)) begin
                forward_b_o = SEL_MEM;
            end else if (writes(memwb, idex.rt)) begin
                forward_b_o = SEL_WB;
            end
        end
    end

`else

    // No bypass paths: wait until the producer reaches MEM/WB, where the
    // register file write lands before the ID read in the same cycle.
    assign hazard = id_valid_i && (src_hit(idex) || src_hit(exmem));

    assign forward_a_o = SEL_RF;
    assign forward_b_o = SEL_RF;

`endif

    // A flush discards the ID instruction, so there is nothing to hold.
    assign stall_o  = hazard && !flush_i;
    assign bubble_o = hazard || flush_i;

    always_comb begin
        idex_next = '0;
        if (id_valid_i && !stall_o && !flush_i) begin
            idex_next.valid     = 1'b1;
            idex_next.reg_write = id_reg_write_i;
            idex_next.mem_read  = id_mem_read_i;
            idex_next.write_reg = id_write_reg_i;
            idex_next.rs        = id_rs_i;
            idex_next.rt        = id_rt_i;
            idex_next.uses_rt   = id_uses_rt_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idex  <= '0;
            exmem <= '0;
            memwb <= '0;
        end else begin
            idex  <= idex_next;
            exmem <= idex;
            memwb <= exmem;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall_o && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_BITS'(1);
        end
    end

    assign stall_count_o = stall_cnt;

    // MEM/WB only needs valid/reg_write/write_reg; the rest rides along.
    logic unused_memwb;
    assign unused_memwb = ^memwb;

endmodule

// File: tb/tb_forwarding_control_unit.sv
// Directed bench for forwarding_control_unit; a second narrow-counter
// instance shares the stimulus to reach counter saturation quickly.

module tb_forwarding_control_unit;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [4:0] id_write_reg;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       id_valid;
    logic       flush;

    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        stall;
    logic        bubble;
    logic [15:0] cnt;

    logic [1:0] s_fa;
    logic [1:0] s_fb;
    logic       s_stall;
    logic       s_bubble;
    logic [2:0] s_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

`ifdef FORWARDING_CONTROL_FORWARDING_EN
    localparam int NST = 1;
`else
    localparam int NST = 2;
`endif

    forwarding_control_unit #(.REG_BITS(5), .CNT_BITS(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rs_i        (id_rs),
        .id_rt_i        (id_rt),
        .id_uses_rt_i   (id_uses_rt),
        .id_write_reg_i (id_write_reg),
        .id_reg_write_i (id_reg_write),
        .id_mem_read_i  (id_mem_read),
        .id_valid_i     (id_valid),
        .flush_i        (flush),
        .forward_a_o    (fa),
        .forward_b_o    (fb),
        .stall_o        (stall),
        .bubble_o       (bubble),
        .stall_count_o  (cnt)
    );

    forwarding_control_unit #(.REG_BITS(5), .CNT_BITS(3)) dut_sat (
        .clk            (clk),
        .reset          (reset),
        .id_rs_i        (id_rs),
        .id_rt_i        (id_rt),
        .id_uses_rt_i   (id_uses_rt),
        .id_write_reg_i (id_write_reg),
        .id_reg_write_i (id_reg_write),
        .id_mem_read_i  (id_mem_read),
        .id_valid_i     (id_valid),
        .flush_i        (flush),
        .forward_a_o    (s_fa),
        .forward_b_o    (s_fb),
        .stall_o        (s_stall),
        .bubble_o       (s_bubble),
        .stall_count_o  (s_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic ur, input logic [4:0] wr,
                         input logic rw, input logic mr,
                         input logic v, input logic f);
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rt   = ur;
        id_write_reg = wr;
        id_reg_write = rw;
        id_mem_read  = mr;
        id_valid     = v;
        flush        = f;
    endtask

    task automatic nop();
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    function automatic int sat7(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    initial begin
        nop();
        reset = 1'b1;
        #2 reset = 1'b0;

        // reset with random ID activity: nothing in flight
        for (int i = 0; i < 3; i++) begin
            drive(5'($urandom), 5'($urandom), 1'($urandom),
                  5'($urandom), 1'($urandom), 1'($urandom),
                  1'b1, 1'b0);
            @(negedge clk);
            chk("rst_fa", 32'(fa), 32'd0);
            chk("rst_fb", 32'(fb), 32'd0);
            chk("rst_stall", 32'(stall), 32'd0);
            chk("rst_bubble", 32'(bubble), 32'd0);
            chk("rst_cnt", 32'(cnt), 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        nop();
        @(negedge clk);
        chk("post_rst_fa", 32'(fa), 32'd0);
        chk("post_rst_fb", 32'(fb), 32'd0);
        tick();

        // add $3,$1,$2 ; sub $5,$3,$4
        drive(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive(5'd3, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef FORWARDING_CONTROL_FORWARDING_EN
        @(negedge clk);
        chk("b2b_stall", 32'(stall), 32'd0);
        tick();
        nop();
        @(negedge clk);
        chk("b2b_fa", 32'(fa), 32'd2);
        chk("b2b_fb", 32'(fb), 32'd0);
        chk("b2b_stall_ex", 32'(stall), 32'd0);
`else
        @(negedge clk);
        chk("b2b_stall1", 32'(stall), 32'd1);
        chk("b2b_bubble1", 32'(bubble), 32'd1);
        tick();
        @(negedge clk);
        chk("b2b_stall2", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        chk("b2b_stall3", 32'(stall), 32'd0);
        chk("b2b_bubble3", 32'(bubble), 32'd0);
        tick();
        exp_cnt += 2;
        nop();
        @(negedge clk);
        chk("b2b_fa", 32'(fa), 32'd0);
        chk("b2b_fb", 32'(fb), 32'd0);
        chk("b2b_cnt", 32'(cnt), 32'(exp_cnt));
`endif
        drain();

        // add $3 ; and $7,$1,$2 ; sub $5,$3,$4
        drive(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive(5'd1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive(5'd3, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef FORWARDING_CONTROL_FORWARDING_EN
        @(negedge clk);
        chk("d2_stall", 32'(stall), 32'd0);
        tick();
        nop();
        @(negedge clk);
        chk("d2_fa", 32'(fa), 32'd1);
`else
        @(negedge clk);
        chk("d2_stall1", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        chk("d2_stall2", 32'(stall), 32'd0);
        tick();
        exp_cnt += 1;
        nop();
        @(negedge clk);
        chk("d2_fa", 32'(fa), 32'd0);
        chk("d2_cnt", 32'(cnt), 32'(exp_cnt));
`endif
        drain();

        // add $3 ; add $3 ; or $6,$3,$3
        drive(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive(5'd3, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef FORWARDING_CONTROL_FORWARDING_EN
        @(negedge clk);
        chk("dbl_stall", 32'(stall), 32'd0);
        tick();
        nop();
        @(negedge clk);
        chk("dbl_fa", 32'(fa), 32'd2);
        chk("dbl_fb", 32'(fb), 32'd2);
`else
        @(negedge clk);
        chk("dbl_stall1", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        chk("dbl_stall2", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        chk("dbl_stall3", 32'(stall), 32'd0);
        tick();
        exp_cnt += 2;
        nop();
        @(negedge clk);
        chk("dbl_fa", 32'(fa), 32'd0);
        chk("dbl_fb", 32'(fb), 32'd0);
`endif
        drain();

        // lw $2,0($1) ; add $4,$2,$1
        drive(5'd1, 5'd2, 1'b0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(5'd2, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < NST; k++) begin
            @(negedge clk);
            chk("lu_stall", 32'(stall), 32'd1);
            chk("lu_bubble", 32'(bubble), 32'd1);
            tick();
        end
        exp_cnt += NST;
        @(negedge clk);
        chk("lu_release", 32'(stall), 32'd0);
        chk("lu_cnt", 32'(cnt), 32'(exp_cnt));
        tick();
        nop();
        @(negedge clk);
`ifdef FORWARDING_CONTROL_FORWARDING_EN
        chk("lu_fa", 32'(fa), 32'd1);
`else
        chk("lu_fa", 32'(fa), 32'd0);
`endif
        chk("lu_fb", 32'(fb), 32'd0);
        drain();

        // lw $0 ; add $4,$0,$1: $0 never creates a dependency
        drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(5'd0, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("r0_stall", 32'(stall), 32'd0);
        chk("r0_bubble", 32'(bubble), 32'd0);
        tick();
        nop();
        @(negedge clk);
        chk("r0_fa", 32'(fa), 32'd0);
        drain();

        // lw $2 ; add $4,$2,$1 flushed in the hazard cycle
        drive(5'd1, 5'd2, 1'b0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(5'd2, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("fl_stall", 32'(stall), 32'd0);
        chk("fl_bubble", 32'(bubble), 32'd1);
        tick();
        nop();
        @(negedge clk);
        chk("fl_after_stall", 32'(stall), 32'd0);
        chk("fl_cnt", 32'(cnt), 32'(exp_cnt));
        drain();

        // repeated load-use pairs drive the 3-bit counter into saturation
        @(negedge clk);
        chk("sat_pre", 32'(s_cnt), 32'(sat7(exp_cnt)));
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(5'd1, 5'd2, 1'b0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
            tick();
            drive(5'd2, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
            repeat (NST) tick();
            tick();
            exp_cnt += NST;
            nop();
            @(negedge clk);
            chk("sat_cnt16", 32'(cnt), 32'(exp_cnt));
            chk("sat_cnt3", 32'(s_cnt), 32'(sat7(exp_cnt)));
            tick();
        end
        drain();

        // reset asserted in the middle of a load-use stall
        drive(5'd1, 5'd2, 1'b0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(5'd2, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("mid_stall", 32'(stall), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_bubble", 32'(bubble), 32'd0);
        chk("mid_rst_cnt", 32'(cnt), 32'd0);
        chk("mid_rst_cnt3", 32'(s_cnt), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("mid_tag_lost", 32'(stall), 32'd0);
        tick();
        nop();
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/forwarding_control_unit.md
# forwarding_control_unit

Pipeline hazard controller for the five-stage MIPS core. It tracks register-destination tags of in-flight instructions through ID/EX, EX/MEM and MEM/WB. It drives the 2-bit selectors of the EX-stage operand-A/B 3-to-1 forwarding multiplexers, asserts load-use stalls and bubbles, and keeps a saturating stall-cycle counter for performance debug.

## Interface
- REG_BITS, 5, register-index width
- CNT_BITS, 16, stall counter width
- clk  input  1  core clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all state
- id_rs_i  input  REG_BITS  rs of instruction in ID
- id_rt_i  input  REG_BITS  rt of instruction in ID
- id_uses_rt_i  input  1  ID instruction reads rt as a source
- id_write_reg_i  input  REG_BITS  destination register of ID instruction (after RegDst mux)
- id_reg_write_i  input  1  ID instruction writes register file
- id_mem_read_i  input  1  ID instruction is a load
- id_valid_i  input  1  ID holds a real instruction
- flush_i  input  1  taken branch/jump: squash the ID instruction
- forward_a_o  output  2  operand-A mux select for instruction in EX
- forward_b_o  output  2  operand-B mux select for instruction in EX
- stall_o  output  1  hold PC and IF/ID register
- bubble_o  output  1  zero control bits entering ID/EX
- stall_count_o  output  CNT_BITS  saturating count of stall cycles

## Operation
- Select encoding (matches mux inputs): 2'b00 register-file data, 2'b01 MEM/WB write-back data, 2'b10 EX/MEM ALU result; 2'b11 never driven.
- Tag pipeline: three registered stages (IDEX, EXMEM, MEMWB), each holding {valid, reg_write, mem_read, write_reg, rs, rt, uses_rt}.
- Per clock: EXMEM <= IDEX, MEMWB <= EXMEM always. IDEX <= ID fields when id_valid_i & !stall_o & !flush_i; otherwise IDEX <= invalid (bubble).
- A stage "writes r" iff valid & reg_write & write_reg == r & r != 0.
- forward_a_o: 2'b10 if EXMEM writes IDEX.rs; else 2'b01 if MEMWB writes IDEX.rs; else 2'b00. EXMEM has priority on double match. Forced 2'b00 when IDEX invalid.
- forward_b_o: same using IDEX.rt, and only when IDEX.uses_rt; else 2'b00.
- Load-use hazard: IDEX valid & mem_read & IDEX writes (id_rs_i, or id_rt_i when id_uses_rt_i), with id_valid_i high -> stall_o = 1, bubble_o = 1.
- flush_i has priority: when flush_i = 1, stall_o = 0 and bubble_o = 1.
- stall_count_o increments each cycle stall_o = 1; holds at all-ones.
- Outputs forward_*, stall_o and bubble_o are combinational from tags and ID inputs; no registered outputs other than the counter.

## Timing
- Reset (async assert, sync release by system): all tags invalid, forward_a_o = forward_b_o = 2'b00, stall_o = 0, bubble_o = 0, stall_count_o = 0.
- Reset asserted mid-stall clears the stall immediately; the in-flight load tag is lost.
- Back-to-back dependency (ALU -> consumer): forwarding 2'b10 in the consumer's EX cycle, zero stall.
- Distance-2 dependency: 2'b01.
- Distance-3 dependency: 2'b00 (register file writes first half, reads second half).
- Load-use: exactly 1 stall cycle; the following EX cycle sees 2'b01 from MEMWB.
- Writes to $0 never forward or stall.

## Configuration
- FORWARDING_CONTROL_FORWARDING_EN defined: behaviour above.
- Not defined: forward_a_o/forward_b_o tied 2'b00. stall_o = bubble_o = 1 whenever IDEX or EXMEM writes an ID source register (any instruction type, not only loads). ALU -> consumer costs 2 stall cycles, distance-2 costs 1, loads cost 2. Counter behaviour unchanged.

## Test plan
- Reset: hold reset = 0 with random ID inputs -> all outputs 0; release, tags empty, forwards 2'b00.
- add $3 then sub $5,$3,$4 -> in sub's EX cycle forward_a_o = 2'b10, stall_o never 1; with one independent instruction between -> 2'b01.
- Double match: add $3; add $3; or $6,$3,$3 -> forward_a_o = forward_b_o = 2'b10 (EXMEM priority).
- lw $2 then add $4,$2,$1 -> stall_o = bubble_o = 1 for exactly 1 cycle, stall_count_o = 1, then forward_a_o = 2'b01; with $0 as destination -> no stall.
- lw $2 with flush_i = 1 in the hazard cycle -> stall_o = 0, bubble_o = 1; preload counter to 0xFFFE, 3 stalls -> stays 0xFFFF.
- FORWARDING_CONTROL_FORWARDING_EN undefined: add $3 then sub $5,$3,$4 -> 2 stall cycles, forwards 2'b00 throughout.
